// File: rtl/adpll_mod_tx.sv
// Byte FIFO + LSB-first serialiser driving data_mod of adpll_ctr0, one bit per SPB ref cycles.
// Optional 8'hAA burst preamble when ADPLL_MOD_PREAMBLE_EN is defined.
module adpll_mod_tx #(
    parameter int SPB        = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] adpll_mode,
    input  logic       channel_lock,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       data_mod,
    output logic       tx_busy,
    output logic       bit_strobe,
    output logic       abort
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(SPB);
    localparam logic [CW-1:0] CNT_MAX  = CW'(SPB - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifdef ADPLL_MOD_PREAMBLE_EN
        S_PRE  = 2'd1,
`endif
        S_DATA = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bidx_q, bidx_d;
    logic [7:0]      shift_q, shift_d;
    logic            mod_q, mod_d;
    logic            strobe_q, strobe_d;
    logic            abort_q, abort_d;
    logic            rdy_q, rdy_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [7:0]      mem [FIFO_DEPTH];

    logic            active, empty, push, pop, from_pre;
    logic [7:0]      head;
    logic [2:0]      nxt_idx;

    assign active   = en && (adpll_mode == 2'd3) && channel_lock;
    assign empty    = (count_q == '0);
    assign tx_ready = en && rdy_q;
    assign push     = tx_valid && tx_ready;
    assign head     = mem[rd_ptr_q];
    assign nxt_idx  = bidx_q + 3'd1;

`ifdef ADPLL_MOD_PREAMBLE_EN
    assign from_pre = (state_q == S_PRE);
`else
    assign from_pre = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bidx_d   = bidx_q;
        shift_d  = shift_q;
        mod_d    = mod_q;
        strobe_d = 1'b0;
        abort_d  = 1'b0;
        pop      = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                bidx_d = '0;
                mod_d  = 1'b0;
                if (active && !empty) begin
                    strobe_d = 1'b1;
`ifdef ADPLL_MOD_PREAMBLE_EN
                    state_d  = S_PRE;
                    shift_d  = 8'hAA;
                    mod_d    = 1'b0;
`else
                    state_d  = S_DATA;
                    shift_d  = head;
                    mod_d    = head[0];
                    pop      = 1'b1;
`endif
                end
            end
            default: begin
                // Loss of active wins over a coinciding symbol boundary.
                if (!active) begin
                    state_d = S_IDLE;
                    mod_d   = 1'b0;
                    abort_d = 1'b1;
                    cnt_d   = '0;
                    bidx_d  = '0;
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d = '0;
                    if (bidx_q == 3'd7) begin
                        bidx_d = '0;
                        if (from_pre || !empty) begin
                            state_d  = S_DATA;
                            shift_d  = head;
                            mod_d    = head[0];
                            pop      = 1'b1;
                            strobe_d = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            mod_d   = 1'b0;
                        end
                    end else begin
                        bidx_d   = nxt_idx;
                        mod_d    = shift_q[nxt_idx];
                        strobe_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (!en) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
        rdy_d = (count_d != FULL_CNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bidx_q   <= '0;
            shift_q  <= '0;
            mod_q    <= 1'b0;
            strobe_q <= 1'b0;
            abort_q  <= 1'b0;
            rdy_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bidx_q   <= bidx_d;
            shift_q  <= shift_d;
            mod_q    <= mod_d;
            strobe_q <= strobe_d;
            abort_q  <= abort_d;
            rdy_q    <= rdy_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= tx_data;
    end

    assign data_mod   = mod_q;
    assign tx_busy    = (state_q != S_IDLE);
    assign bit_strobe = strobe_q;
    assign abort      = abort_q;

endmodule

// File: tb/tb_adpll_mod_tx.sv
// Directed bench for adpll_mod_tx: reset, single byte, back-to-back, gating, abort, flush, async reset.
module tb_adpll_mod_tx;

    localparam int SPB = 32;
`ifdef ADPLL_MOD_PREAMBLE_EN
    localparam int PRE = 8;
    localparam logic [63:0] PRE_PAT = 64'hAA;
`else
    localparam int PRE = 0;
    localparam logic [63:0] PRE_PAT = 64'h0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, en, channel_lock, tx_valid;
    logic [1:0] adpll_mode;
    logic [7:0] tx_data;
    logic       tx_ready, data_mod, tx_busy, bit_strobe, abort;

    int n_chk = 0;
    int n_err = 0;

    int          n_strb, n_busy, n_gap, n_glitch, n_abort, first_cyc;
    logic [63:0] bits;
    logic        done, any_act;

    always #5 clk = ~clk;

    adpll_mod_tx #(.SPB(SPB), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .adpll_mode(adpll_mode),
        .channel_lock(channel_lock), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .data_mod(data_mod), .tx_busy(tx_busy),
        .bit_strobe(bit_strobe), .abort(abort)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    // Follow one burst at negedges until tx_busy falls, recording bits at each strobe.
    task automatic watch(input int max_cyc);
        int   cyc;
        int   last;
        logic prev;
        logic seen;
        cyc = 0; last = -1; seen = 1'b0; prev = data_mod;
        n_strb = 0; n_busy = 0; n_gap = 0; n_glitch = 0; n_abort = 0;
        first_cyc = -1; bits = '0; done = 1'b0;
        while (cyc < max_cyc && !done) begin
            @(negedge clk);
            cyc++;
            if (bit_strobe) begin
                if (n_strb < 64) bits[n_strb] = data_mod;
                if (n_strb == 0) first_cyc = cyc;
                if (last >= 0 && (cyc - last) != SPB) n_gap++;
                last = cyc;
                n_strb++;
            end else if (tx_busy && data_mod != prev) begin
                n_glitch++;
            end
            prev = data_mod;
            if (abort) n_abort++;
            if (tx_busy) begin
                n_busy++;
                seen = 1'b1;
            end else if (seen) begin
                done = 1'b1;
            end
        end
    endtask

    task automatic idle_watch(input int ncyc);
        any_act = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (tx_busy || data_mod || bit_strobe) any_act = 1'b1;
        end
    endtask

    initial begin
        int ns;
        rst_n = 1'b0; en = 1'b1; adpll_mode = 2'd3; channel_lock = 1'b1;
        tx_data = 8'h55; tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst data_mod", data_mod, 0);
        check_eq("rst tx_ready", tx_ready, 0);
        check_eq("rst tx_busy", tx_busy, 0);
        check_eq("rst bit_strobe", bit_strobe, 0);
        check_eq("rst abort", abort, 0);
        tx_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("post-rst tx_ready", tx_ready, 1);
        check_eq("post-rst data_mod", data_mod, 0);
        check_eq("post-rst tx_busy", tx_busy, 0);

        // Single byte 8'hB4 -> 0,0,1,0,1,1,0,1
        push(8'hB4);
        watch(2000);
        check_eq("b4 done", done, 1);
        check_eq("b4 first strobe cyc", first_cyc, 2);
        check_eq("b4 bits", bits, (64'hB4 << PRE) | PRE_PAT);
        check_eq("b4 strobes", n_strb, 8 + PRE);
        check_eq("b4 busy cycles", n_busy, (8 + PRE) * SPB);
        check_eq("b4 gaps", n_gap, 0);
        check_eq("b4 glitches", n_glitch, 0);
        check_eq("b4 end data_mod", data_mod, 0);

`ifdef ADPLL_MOD_PREAMBLE_EN
        push(8'hFF);
        watch(2000);
        check_eq("pre ff bits", bits, 64'hFFAA);
        check_eq("pre ff busy cycles", n_busy, 512);
`endif

        // Back-to-back, queued while lock is low
        channel_lock = 1'b0;
        push(8'h01); push(8'h80); push(8'hFF);
        @(negedge clk);
        check_eq("b2b not full at 3", tx_ready, 1);
        push(8'h00);
        @(negedge clk);
        check_eq("b2b full tx_ready", tx_ready, 0);
        idle_watch(20);
        check_eq("lock gating quiet", any_act, 0);
        channel_lock = 1'b1;
        watch(3000);
        check_eq("b2b done", done, 1);
        check_eq("b2b first strobe cyc", first_cyc, 1);
        check_eq("b2b bits", bits, (64'h00FF8001 << PRE) | PRE_PAT);
        check_eq("b2b strobes", n_strb, 32 + PRE);
        check_eq("b2b gaps", n_gap, 0);
        check_eq("b2b busy cycles", n_busy, (32 + PRE) * SPB);
        check_eq("b2b tx_ready after", tx_ready, 1);

        // Abort: queue under RX mode, drop lock on the bit3->bit4 boundary
        adpll_mode = 2'd2;
        push(8'h5A); push(8'h3C); push(8'h96);
        idle_watch(20);
        check_eq("mode gating quiet", any_act, 0);
        adpll_mode = 2'd3;
        ns = 0;
        for (int k = 0; k < 2000 && ns < 4 + PRE; k++) begin
            @(negedge clk);
            if (bit_strobe) ns++;
        end
        check_eq("abort reach bit3", ns, 4 + PRE);
        check_eq("abort bit3 value", data_mod, 1);
        repeat (31) @(negedge clk);
        check_eq("abort bit3 held", data_mod, 1);
        channel_lock = 1'b0;
        @(negedge clk);
        check_eq("abort pulse", abort, 1);
        check_eq("abort no strobe", bit_strobe, 0);
        check_eq("abort data_mod", data_mod, 0);
        check_eq("abort tx_busy", tx_busy, 0);
        @(negedge clk);
        check_eq("abort one cycle", abort, 0);
        repeat (10) @(negedge clk);
        channel_lock = 1'b1;
        watch(2000);
        check_eq("resume done", done, 1);
        check_eq("resume first strobe cyc", first_cyc, 1);
        check_eq("resume bits", bits, (64'h963C << PRE) | PRE_PAT);
        check_eq("resume strobes", n_strb, 16 + PRE);
        check_eq("resume busy cycles", n_busy, (16 + PRE) * SPB);
        check_eq("resume no abort", n_abort, 0);

        // en low flushes queued bytes
        channel_lock = 1'b0;
        push(8'h11); push(8'h22);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check_eq("en low tx_ready", tx_ready, 0);
        en = 1'b1;
        channel_lock = 1'b1;
        idle_watch(10);
        check_eq("flush quiet", any_act, 0);

        // Async reset mid-burst
        push(8'hFF);
        repeat (40) @(negedge clk);
        check_eq("mid-burst data_mod", data_mod, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async rst data_mod", data_mod, 0);
        check_eq("async rst tx_busy", tx_busy, 0);
        check_eq("async rst tx_ready", tx_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_watch(5);
        check_eq("post async rst quiet", any_act, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
